// File: rtl/dpdm_rx.sv
// dpdm_rx: DP/DM line receiver. Detects SOP/SYNC, forwards line bits, detects EOP and classifies by length.
// Define DPDM_RX_SYNC_EN to insert a 2-flop input synchronizer (reset to J), adding two cycles of latency.
module dpdm_rx #(
    parameter int TOK_LEN  = 28,
    parameter int DATA_LEN = 92,
    parameter int HS_LEN   = 12,
    parameter int MAX_LEN  = 100,
    parameter int IDLE_RUN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    output logic       bstr,
    output logic       bstr_valid,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic [6:0] pkt_len,
    output logic [1:0] pkt_type,
    output logic       pkt_err,
    output logic [1:0] err_code
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_ERR} state_t;

    localparam int RUN_W = $clog2(IDLE_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_END = RUN_W'(IDLE_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [6:0] MAX_C = 7'(MAX_LEN);
    localparam logic [1:0] ERR_SYNC = 2'b00, ERR_EOP = 2'b01, ERR_OVF = 2'b10, ERR_SE1 = 2'b11;

    function automatic logic [1:0] classify(input logic [6:0] len);
        if (len == 7'(TOK_LEN))       return 2'b01;
        else if (len == 7'(DATA_LEN)) return 2'b10;
        else if (len == 7'(HS_LEN))   return 2'b11;
        else                          return 2'b00;
    endfunction

    logic [1:0] line;

`ifdef DPDM_RX_SYNC_EN
    logic [1:0] sync_p0_q, sync_p1_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0_q <= 2'b10;
            sync_p1_q <= 2'b10;
        end else begin
            sync_p0_q <= {dp, dm};
            sync_p1_q <= sync_p0_q;
        end
    end
    assign line = sync_p1_q;
`else
    assign line = {dp, dm};
`endif

    state_t           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             bstr_q, bstr_d, bstr_valid_q, bstr_valid_d;
    logic             pkt_start_q, pkt_start_d, pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d;
    logic [6:0]       pkt_len_q, pkt_len_d;
    logic [1:0]       pkt_type_q, pkt_type_d, err_code_q, err_code_d;
    logic             is_j, is_k, is_se0, is_se1, sync_dp;

    assign is_j   = (line == 2'b10);
    assign is_k   = (line == 2'b01);
    assign is_se0 = (line == 2'b00);
    assign is_se1 = (line == 2'b11);
    // Expected dp for SYNC sample index cnt: K J K J K J K K
    assign sync_dp = (cnt_q == 7'd7) ? 1'b0 : cnt_q[0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_d        = '0;
        bstr_d       = 1'b0;
        bstr_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_err_d    = 1'b0;
        pkt_len_d    = pkt_len_q;
        pkt_type_d   = pkt_type_q;
        err_code_d   = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (is_k) begin
                    state_d      = S_SYNC;
                    cnt_d        = 7'd1;
                    bstr_valid_d = 1'b1;
                    pkt_start_d  = 1'b1;
                end
            end
            S_SYNC: begin
                if (is_se1) begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_SE1;
                end else if ((is_j || is_k) && line[1] == sync_dp) begin
                    bstr_d       = line[1];
                    bstr_valid_d = 1'b1;
                    cnt_d        = cnt_q + 7'd1;
                    if (cnt_q == 7'd7) state_d = S_DATA;
                end else begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_SYNC;
                end
            end
            S_DATA: begin
                // SE0 is tested before overflow so an EOP on the last legal count still completes
                if (is_se0) begin
                    state_d = S_EOP1;
                end else if (is_se1) begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_SE1;
                end else if (cnt_q + 7'd1 == MAX_C) begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_OVF;
                end else begin
                    bstr_d       = line[1];
                    bstr_valid_d = 1'b1;
                    cnt_d        = cnt_q + 7'd1;
                end
            end
            S_EOP1: begin
                if (is_se0) begin
                    state_d = S_EOP2;
                end else begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_EOP;
                end
            end
            S_EOP2: begin
                if (is_j) begin
                    state_d    = S_IDLE;
                    pkt_done_d = 1'b1;
                    pkt_len_d  = cnt_q;
                    pkt_type_d = classify(cnt_q);
                end else begin
                    state_d = S_ERR; pkt_err_d = 1'b1; err_code_d = ERR_EOP;
                end
            end
            S_ERR: begin
                if (is_j) begin
                    if (run_q + RUN_ONE == RUN_END) state_d = S_IDLE;
                    else                            run_d   = run_q + RUN_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            run_q        <= '0;
            bstr_q       <= 1'b0;
            bstr_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            pkt_len_q    <= '0;
            pkt_type_q   <= '0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            bstr_q       <= bstr_d;
            bstr_valid_q <= bstr_valid_d;
            pkt_start_q  <= pkt_start_d;
            pkt_done_q   <= pkt_done_d;
            pkt_err_q    <= pkt_err_d;
            pkt_len_q    <= pkt_len_d;
            pkt_type_q   <= pkt_type_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bstr       = bstr_q;
    assign bstr_valid = bstr_valid_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_err    = pkt_err_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_type   = pkt_type_q;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_dpdm_rx.sv
// Bench for dpdm_rx: scenario table with hand-derived totals, a mid-packet reset sequence and a random
// packet stream, all checked cycle by cycle against a packet-level parser of the line symbol stream.
`timescale 1ns/1ps
module tb_dpdm_rx;
`ifdef DPDM_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int MAX_LEN  = 100;
    localparam int IDLE_RUN = 8;

    logic       clk = 1'b0;
    logic       rst, dp, dm;
    logic       bstr, bstr_valid, pkt_start, pkt_done, pkt_err;
    logic [6:0] pkt_len;
    logic [1:0] pkt_type, err_code;

    dpdm_rx dut (
        .clk(clk), .rst(rst), .dp(dp), .dm(dm),
        .bstr(bstr), .bstr_valid(bstr_valid), .pkt_start(pkt_start), .pkt_done(pkt_done),
        .pkt_len(pkt_len), .pkt_type(pkt_type), .pkt_err(pkt_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       bstr, valid, start, done, err;
        logic [6:0] len;
        logic [1:0] typ, code;
    } exp_t;

    typedef struct {
        string name;
        string seq;
        int    n_valid, n_start, n_done, n_err, code, len, typ;
    } vec_t;

    exp_t  expq[$];
    vec_t  tbl[$];
    int    vectors = 0, miscompares = 0;
    int    n_valid, n_start, n_done, n_err;
    string SYNC = "KJKJKJKK";

    function automatic logic [1:0] len_type(input int n);
        if (n == 28) return 2'b01;
        if (n == 92) return 2'b10;
        if (n == 12) return 2'b11;
        return 2'b00;
    endfunction

    // Packet-level parser of a symbol string (J, K, 0=SE0, 1=SE1): one expected output record per sample.
    function automatic void model(input string s);
        string sync_s = "KJKJKJKK";
        exp_t  h, e;
        int    i, n, nbits, run, k;
        bit    fail;
        byte   c;
        expq.delete();
        h = '0; n = s.len(); i = 0;
        while (i < n) begin
            c = s[i]; e = h;
            if (c != "K") begin expq.push_back(e); i++; continue; end
            e.start = 1'b1; e.valid = 1'b1; expq.push_back(e); i++;
            nbits = 1; fail = 1'b0; k = 1;
            while (k < 8 && i < n && !fail) begin
                c = s[i]; i++; e = h;
                if (c == "1") begin fail = 1'b1; h.code = 2'b11; e = h; e.err = 1'b1; end
                else if (c != sync_s[k]) begin fail = 1'b1; h.code = 2'b00; e = h; e.err = 1'b1; end
                else begin e.valid = 1'b1; e.bstr = (c == "J"); nbits++; end
                expq.push_back(e); k++;
            end
            while (!fail && i < n && s[i] != "0") begin
                c = s[i]; i++; e = h;
                if (c == "1") begin fail = 1'b1; h.code = 2'b11; e = h; e.err = 1'b1; end
                else if (nbits + 1 == MAX_LEN) begin fail = 1'b1; h.code = 2'b10; e = h; e.err = 1'b1; end
                else begin e.valid = 1'b1; e.bstr = (c == "J"); nbits++; end
                expq.push_back(e);
            end
            if (!fail && i < n) begin
                expq.push_back(h); i++;
                if (i < n) begin
                    c = s[i]; i++;
                    if (c == "0") begin
                        expq.push_back(h);
                        if (i < n) begin
                            c = s[i]; i++;
                            if (c == "J") begin
                                h.len = 7'(nbits); h.typ = len_type(nbits); e = h; e.done = 1'b1;
                            end else begin
                                fail = 1'b1; h.code = 2'b01; e = h; e.err = 1'b1;
                            end
                            expq.push_back(e);
                        end
                    end else begin
                        fail = 1'b1; h.code = 2'b01; e = h; e.err = 1'b1; expq.push_back(e);
                    end
                end
            end
            if (fail) begin
                run = 0;
                while (i < n && run < IDLE_RUN) begin
                    run = (s[i] == "J") ? run + 1 : 0;
                    expq.push_back(h); i++;
                end
            end
        end
    endfunction

    function automatic string pat_bits(input int n);
        string s = "";
        for (int i = 0; i < n; i++) begin
            if (i % 3 == 0) s = {s, "K"};
            else            s = {s, "J"};
        end
        return s;
    endfunction

    function automatic string rand_bits(input int n);
        string s = "";
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) s = {s, "J"};
            else                           s = {s, "K"};
        end
        return s;
    endfunction

    function automatic string j_run(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, "J"};
        return s;
    endfunction

    task automatic set_line(input byte c);
        case (c)
            "J":     begin dp = 1'b1; dm = 1'b0; end
            "K":     begin dp = 1'b0; dm = 1'b1; end
            "0":     begin dp = 1'b0; dm = 1'b0; end
            default: begin dp = 1'b1; dm = 1'b1; end
        endcase
    endtask

    task automatic check(input string name, input int idx, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s sample %0d: got %h required %h (bstr,vld,start,done,err,len,type,code)",
                     name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input string field, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s %s: got %0d required %0d", name, field, act, exp);
        end
    endtask

    function automatic exp_t outs();
        return {bstr, bstr_valid, pkt_start, pkt_done, pkt_err, pkt_len, pkt_type, err_code};
    endfunction

    task automatic reset_dut();
        rst = 1'b1; set_line("J");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_stream(input string name, input string s, input bit do_rst);
        int  n;
        byte c;
        model(s);
        n = s.len();
        if (do_rst) reset_dut();
        n_valid = 0; n_start = 0; n_done = 0; n_err = 0;
        for (int k = 0; k < n + LAT; k++) begin
            c = "J";
            if (k < n) c = s[k];
            set_line(c);
            @(posedge clk); #1;
            n_valid += int'(bstr_valid); n_start += int'(pkt_start);
            n_done  += int'(pkt_done);   n_err   += int'(pkt_err);
            if (k >= LAT) check(name, k - LAT, outs(), expq[k - LAT]);
        end
    endtask

    task automatic add_vec(input string name, input string seq, input int nv, input int ns, input int nd,
                           input int ne, input int code, input int len, input int typ);
        vec_t v;
        v.name = name; v.seq = seq; v.n_valid = nv; v.n_start = ns; v.n_done = nd;
        v.n_err = ne; v.code = code; v.len = len; v.typ = typ;
        tbl.push_back(v);
    endtask

    initial begin
        string s, p;
        int    kind, r;
        rst = 1'b1; dp = 1'b1; dm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, outs(), '0);
        rst = 1'b0;

        //        name          sequence                                                                 vld strt done err code len typ
        add_vec("handshake",   {"JJJ", SYNC, pat_bits(4), "00J", "JJ"},                                  12, 1, 1, 0, 0, 12, 3);
        add_vec("tok_data",    {SYNC, pat_bits(20), "00J", "J", SYNC, pat_bits(84), "00J", "J"},        120, 2, 2, 0, 0, 92, 2);
        add_vec("hs_tok_b2b",  {SYNC, pat_bits(4), "00J", SYNC, pat_bits(20), "00J"},                    40, 2, 2, 0, 0, 28, 1);
        add_vec("bad_sync",    {"J", "KJKK", j_run(8), SYNC, pat_bits(4), "00J"},                         15, 2, 1, 1, 0, 12, 3);
        add_vec("overflow",    {"J", SYNC, pat_bits(92), j_run(8)},                                       99, 1, 0, 1, 2, 0, 0);
        add_vec("se0_then_k",  {SYNC, pat_bits(4), "0K", j_run(8)},                                      12, 1, 0, 1, 1, 0, 0);
        add_vec("se1_data",    {SYNC, pat_bits(10), "1", pat_bits(3), j_run(8)},                         18, 1, 0, 1, 3, 0, 0);
        add_vec("se0_x3",      {SYNC, pat_bits(4), "000", j_run(8)},                                     12, 1, 0, 1, 1, 0, 0);
        add_vec("se1_sync",    {"KJK1", j_run(8)},                                                        3, 1, 0, 1, 3, 0, 0);
        add_vec("len_nomatch", {SYNC, pat_bits(7), "00J"},                                               15, 1, 1, 0, 0, 15, 0);
        add_vec("se0_at_max",  {SYNC, pat_bits(91), "00J"},                                              99, 1, 1, 0, 0, 99, 0);
        add_vec("idle_noise",  {"1J0J", SYNC, pat_bits(4), "00J"},                                       12, 1, 1, 0, 0, 12, 3);
        add_vec("k_in_err",    {"KK", "JJJK", j_run(8), SYNC, pat_bits(4), "00J"},                       13, 2, 1, 1, 0, 12, 3);

        foreach (tbl[i]) begin
            run_stream(tbl[i].name, tbl[i].seq, 1'b1);
            check_int(tbl[i].name, "bstr_valid count", n_valid, tbl[i].n_valid);
            check_int(tbl[i].name, "pkt_start count", n_start, tbl[i].n_start);
            check_int(tbl[i].name, "pkt_done count", n_done, tbl[i].n_done);
            check_int(tbl[i].name, "pkt_err count", n_err, tbl[i].n_err);
            check_int(tbl[i].name, "err_code", int'(err_code), tbl[i].code);
            check_int(tbl[i].name, "pkt_len", int'(pkt_len), tbl[i].len);
            check_int(tbl[i].name, "pkt_type", int'(pkt_type), tbl[i].typ);
        end

        // Reset asserted while DATA bits are being forwarded
        reset_dut();
        s = {SYNC, pat_bits(6), "JK"};
        for (int k = 0; k < 14 + LAT; k++) begin
            set_line(s[k]);
            @(posedge clk); #1;
        end
        check_int("rst_mid", "bstr_valid before rst", int'(bstr_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_clear", 0, outs(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_stream("rst_tail", {pat_bits(6), "00J", j_run(8)}, 1'b0);
        check_int("rst_tail", "pkt_err count", n_err, 1);
        check_int("rst_tail", "err_code", int'(err_code), 0);
        check_int("rst_tail", "pkt_done count", n_done, 0);

        // Random packet mix, including gaps too short to finish draining after an error
        s = "";
        for (int pk = 0; pk < 30; pk++) begin
            s = {s, j_run($urandom_range(1, 10))};
            if ($urandom_range(0, 5) == 0) s = {s, "1J"};
            kind = $urandom_range(0, 7);
            case (kind)
                0: p = {SYNC, rand_bits(4), "00J"};
                1: p = {SYNC, rand_bits(20), "00J"};
                2: p = {SYNC, rand_bits(84), "00J"};
                3: p = {SYNC, rand_bits($urandom_range(1, 91)), "00J"};
                4: begin
                    p = SYNC;
                    r = $urandom_range(1, 7);
                    case ($urandom_range(0, 2))
                        0: p.putc(r, (p[r] == "J") ? "K" : "J");
                        1: p.putc(r, "0");
                        default: p.putc(r, "1");
                    endcase
                    p = {p, rand_bits(5), "00J"};
                end
                5: p = {SYNC, rand_bits($urandom_range(0, 40)), "1", rand_bits(3), "00J"};
                6: begin
                    p = {SYNC, rand_bits($urandom_range(0, 30))};
                    case ($urandom_range(0, 3))
                        0: p = {p, "0K"};
                        1: p = {p, "000"};
                        2: p = {p, "00K"};
                        default: p = {p, "001"};
                    endcase
                end
                default: p = {SYNC, rand_bits($urandom_range(92, 97)), "00J"};
            endcase
            s = {s, p};
        end
        s = {s, j_run(10)};
        run_stream("random", s, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
